dmem_responder: RTL and testbench

//  Data-memory responder for the MEM stage of the pipelined mips_32 core.

---
 rtl/mips32_mem_pkg.sv | 13 +
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder_word_array.sv | 26 ++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the mips_32 data-memory path.
package mips32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_OFS_W = 2;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
    );

endinterface

// File: rtl/dmem_responder_word_array.sv
// DEPTH x 32 single-port synchronous word array; rdata only updates on a read.
module dmem_word_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) mem[idx_i] <= wdata_i;
            else      rdata_q    <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one access in flight, stall while waiting,
// one-cycle response pulse with error flag for misaligned/out-of-range addresses.
module dmem_responder
    import mips32_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int WIDX_W = 32 - BYTE_OFS_W;

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [31:0]      addr_q, wdata_q;
    logic             rsp_err_q, load_ok_q;
    logic             accept, access, err;
    logic [31:0]      arr_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // Back-to-back acceptance in the response cycle
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    assign err = (|addr_q[BYTE_OFS_W-1:0]) ||
                 (addr_q[31:BYTE_OFS_W] >= WIDX_W'(DEPTH));

    // rsp_rdata is gated by load_ok_q so stores, errors and reset read back 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err_q <= 1'b0;
            load_ok_q <= 1'b0;
        end else if (access) begin
            rsp_err_q <= err;
            load_ok_q <= !we_q && !err;
        end
    end

    dmem_word_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk     (clk),
        .en_i    (access && !err),
        .we_i    (we_q),
        .idx_i   (addr_q[AW+BYTE_OFS_W-1:BYTE_OFS_W]),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign bus.req_ready = (state_q == IDLE) || (state_q == RESP);
    assign bus.mem_stall = (state_q == WAIT);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = load_ok_q ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance plus a LATENCY=1 rebuild.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if m ();
    dmem_responder_if m1 ();

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut  (.clk(clk), .reset(reset), .bus(m));
    dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(m1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit u1, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (u1) begin
            m1.req_valid = v; m1.req_we = we; m1.req_addr = a; m1.req_wdata = d;
        end else begin
            m.req_valid = v;  m.req_we = we;  m.req_addr = a;  m.req_wdata = d;
        end
    endtask

    // Counts negedges until rsp_valid, summing mem_stall cycles before it
    task automatic wait_rsp(input bit u1, output int n, output int st);
        bit got = 1'b0;
        n = 0; st = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (u1 ? m1.rsp_valid : m.rsp_valid) got = 1'b1;
            else st += int'(u1 ? m1.mem_stall : m.mem_stall);
        end
    endtask

    function automatic logic [31:0] rdata(input bit u1);
        return u1 ? m1.rsp_rdata : m.rsp_rdata;
    endfunction

    function automatic logic rerr(input bit u1);
        return u1 ? m1.rsp_err : m.rsp_err;
    endfunction

    task automatic xact(input bit u1, input string tag, input logic we,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee);
        int n, st;
        drive(u1, 1'b1, we, a, d);
        @(posedge clk);
        #1 drive(u1, 1'b0, we, a, d);
        wait_rsp(u1, n, st);
        chk({tag, " lat"},   n,  u1 ? 32'd2 : 32'd3);
        chk({tag, " stall"}, st, u1 ? 32'd1 : 32'd2);
        chk({tag, " rdata"}, rdata(u1), er);
        chk({tag, " err"},   {31'b0, rerr(u1)}, {31'b0, ee});
    endtask

    initial begin
        int n, st;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // 1. requests during reset are ignored
        repeat (2) begin
            @(negedge clk);
            chk("rst ready", {31'b0, m.req_ready}, 32'd1);
            chk("rst rsp_valid", {31'b0, m.rsp_valid}, 32'd0);
            chk("rst stall", {31'b0, m.mem_stall}, 32'd0);
        end
        chk("rst rdata", m.rsp_rdata, 32'h0);
        chk("rst err", {31'b0, m.rsp_err}, 32'd0);
        drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("post-rst stall", {31'b0, m.mem_stall}, 32'd0);
        chk("post-rst rsp_valid", {31'b0, m.rsp_valid}, 32'd0);

        // 2. store then load same word
        xact(0, "st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xact(0, "ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // 3. errors and boundaries
        xact(0, "st0",   1'b1, 32'h0,   32'h0BADF00D, 32'h0, 1'b0);
        xact(0, "ld13",  1'b0, 32'h13,  32'h0, 32'h0, 1'b1);
        xact(0, "st400", 1'b1, 32'h400, 32'h12345678, 32'h0, 1'b1);
        xact(0, "ld0",   1'b0, 32'h0,   32'h0, 32'h0BADF00D, 1'b0);
        xact(0, "st3fc", 1'b1, 32'h3FC, 32'h11112222, 32'h0, 1'b0);
        xact(0, "ld3fc", 1'b0, 32'h3FC, 32'h0, 32'h11112222, 1'b0);
        xact(0, "ldbig", 1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b1);

        // 4. req_valid held: second request taken in the RESP cycle
        drive(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
        @(posedge clk);
        wait_rsp(0, n, st);
        chk("b2b first lat", n, 32'd3);
        chk("b2b first err", {31'b0, m.rsp_err}, 32'd0);
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
        chk("b2b ready in resp", {31'b0, m.req_ready}, 32'd1);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 32'h20, 32'h0);
        wait_rsp(0, n, st);
        chk("b2b gap", n, 32'd3);
        chk("b2b rdata", m.rsp_rdata, 32'hA5A5A5A5);
        chk("b2b err", {31'b0, m.rsp_err}, 32'd0);

        // 5. reset during WAIT drops the store
        xact(0, "st30a", 1'b1, 32'h30, 32'h0, 32'h0, 1'b0);
        drive(0, 1'b1, 1'b1, 32'h30, 32'h1);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b1, 32'h30, 32'h1);
        @(negedge clk);
        chk("midrst stall before", {31'b0, m.mem_stall}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst ready", {31'b0, m.req_ready}, 32'd1);
        chk("midrst stall", {31'b0, m.mem_stall}, 32'd0);
        chk("midrst rsp_valid", {31'b0, m.rsp_valid}, 32'd0);
        chk("midrst rdata", m.rsp_rdata, 32'h0);
        chk("midrst err", {31'b0, m.rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        xact(0, "ld30", 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);

        // 6. LATENCY=1 instance
        xact(1, "l1 st10", 1'b1, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
        xact(1, "l1 ld10", 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
        xact(1, "l1 ld11", 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
